// File: rtl/pixel_scan_if.sv
// Issue/tag bundle between the frame sequencer and its controller / ray generator.
// The controller side is master; the scheduler is slave.
interface pixel_scan_if #(
  parameter int unsigned SPP_W = 4
);
  logic             start;
  logic             abort;
  logic [SPP_W-1:0] spp_cfg;
  logic             stall;
  logic [9:0]       pixel_x;
  logic [9:0]       pixel_y;
  logic             pixel_valid;
  logic [9:0]       tag_x;
  logic [9:0]       tag_y;
  logic             tag_last;
  logic             tag_valid;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_count;

  modport master (
    output start, abort, spp_cfg, stall,
    input  pixel_x, pixel_y, pixel_valid, tag_x, tag_y, tag_last, tag_valid,
    input  busy, frame_done, frame_count
  );

  modport slave (
    input  start, abort, spp_cfg, stall,
    output pixel_x, pixel_y, pixel_valid, tag_x, tag_y, tag_last, tag_valid,
    output busy, frame_done, frame_count
  );
endinterface

// File: rtl/pixel_scan_scheduler.sv
// Raster-order pixel/sample issuer for generate_ray, with a stall-aware tag delay line
// matched to generate_ray latency so downstream knows which pixel each ray belongs to.
module pixel_scan_scheduler #(
  parameter int unsigned H_RES    = 800,
  parameter int unsigned V_RES    = 600,
  parameter int unsigned SPP_W    = 4,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pixel_scan_if.slave  bus
);
  localparam int unsigned CntW = $clog2(PIPE_LAT) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q;
  logic [9:0]       x_q, y_q;
  logic [SPP_W-1:0] sample_q, spp_q;
  logic             valid_q, busy_q, done_q;
  logic [15:0]      count_q;
  logic [CntW-1:0]  drain_q;

  logic issue, last_sample, last_x, last_y;

  assign issue       = valid_q & ~bus.stall;
  assign last_sample = (sample_q == spp_q - SPP_W'(1));
  assign last_x      = (x_q == 10'(H_RES - 1));
  assign last_y      = (y_q == 10'(V_RES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      sample_q <= '0;
      spp_q    <= SPP_W'(1);
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      drain_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              state_q  <= StRun;
              x_q      <= '0;
              y_q      <= '0;
              sample_q <= '0;
              spp_q    <= (bus.spp_cfg == '0) ? SPP_W'(1) : bus.spp_cfg;
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          StRun: begin
            if (issue) begin
              // Final sample of the frame: hold coordinates, let the pipe drain.
              if (last_sample && last_x && last_y) begin
                state_q <= StDrain;
                valid_q <= 1'b0;
                drain_q <= '0;
              end else if (!last_sample) begin
                sample_q <= sample_q + SPP_W'(1);
              end else begin
                sample_q <= '0;
                if (last_x) begin
                  x_q <= '0;
                  y_q <= y_q + 10'd1;
                end else begin
                  x_q <= x_q + 10'd1;
                end
              end
            end
          end
          StDrain: begin
            if (!bus.stall) begin
              if (drain_q == CntW'(PIPE_LAT - 1)) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                count_q <= count_q + 16'd1;
              end else begin
                drain_q <= drain_q + CntW'(1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  logic [9:0] tx_q [PIPE_LAT];
  logic [9:0] ty_q [PIPE_LAT];
  logic       tl_q [PIPE_LAT];
  logic       tv_q [PIPE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tx_q[i] <= '0;
        ty_q[i] <= '0;
        tl_q[i] <= 1'b0;
        tv_q[i] <= 1'b0;
      end
    end else if (bus.abort) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tl_q[i] <= 1'b0;
        tv_q[i] <= 1'b0;
      end
    end else if (!bus.stall) begin
      tx_q[0] <= x_q;
      ty_q[0] <= y_q;
      tl_q[0] <= valid_q & last_sample;
      tv_q[0] <= valid_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tx_q[i] <= tx_q[i-1];
        ty_q[i] <= ty_q[i-1];
        tl_q[i] <= tl_q[i-1];
        tv_q[i] <= tv_q[i-1];
      end
    end
  end

  assign bus.pixel_x     = x_q;
  assign bus.pixel_y     = y_q;
  assign bus.pixel_valid = valid_q;
  assign bus.tag_x       = tx_q[PIPE_LAT-1];
  assign bus.tag_y       = ty_q[PIPE_LAT-1];
  assign bus.tag_last    = tl_q[PIPE_LAT-1];
  assign bus.tag_valid   = tv_q[PIPE_LAT-1];
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_count = count_q;
endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Scoreboard bench: expected samples queued at frame start, popped as the scheduler
// issues them, then re-queued with a due time to check the tag delay line.
module tb_pixel_scan_scheduler;
  localparam int H = 4;
  localparam int V = 3;
  localparam int LAT = 4;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       last;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_scan_if #(.SPP_W(4)) bus ();

  pixel_scan_scheduler #(
    .H_RES(H), .V_RES(V), .SPP_W(4), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  exp_t pix_q[$];
  exp_t tag_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int issued = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int exp_count = 0;
  bit shifted = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (shifted) begin
        if (bus.tag_valid) begin
          n_cmp++;
          if (tag_q.size() == 0) begin
            n_bad++;
            $display("FAIL tag_unexpected got (%0d,%0d) want none", bus.tag_x, bus.tag_y);
          end else begin
            mon_e = tag_q.pop_front();
            if (bus.tag_x !== mon_e.x || bus.tag_y !== mon_e.y || bus.tag_last !== mon_e.last
                || en_cnt != mon_e.due) begin
              n_bad++;
              $display("FAIL tag got (%0d,%0d,last=%0b,t=%0d) want (%0d,%0d,last=%0b,t=%0d)",
                       bus.tag_x, bus.tag_y, bus.tag_last, en_cnt,
                       mon_e.x, mon_e.y, mon_e.last, mon_e.due);
            end
          end
        end else if (tag_q.size() != 0 && tag_q[0].due == en_cnt) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tag_missing got tag_valid=0 want (%0d,%0d)", tag_q[0].x, tag_q[0].y);
          void'(tag_q.pop_front());
        end
      end
      if (bus.pixel_valid) begin
        n_cmp++;
        if (pix_q.size() == 0) begin
          n_bad++;
          $display("FAIL pix_unexpected got (%0d,%0d) want none", bus.pixel_x, bus.pixel_y);
        end else if (bus.pixel_x !== pix_q[0].x || bus.pixel_y !== pix_q[0].y) begin
          n_bad++;
          $display("FAIL pix got (%0d,%0d) want (%0d,%0d)",
                   bus.pixel_x, bus.pixel_y, pix_q[0].x, pix_q[0].y);
        end
      end
      if (bus.abort) begin
        pix_q.delete();
        tag_q.delete();
        shifted = 1'b1;
      end else begin
        if (bus.pixel_valid && !bus.stall && pix_q.size() != 0) begin
          mon_e = pix_q.pop_front();
          mon_e.due = en_cnt + LAT;
          tag_q.push_back(mon_e);
          issued = issued + 1;
        end
        shifted = !bus.stall;
        if (!bus.stall) en_cnt = en_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] cfg, output int s);
    int spp;
    spp = (cfg == 4'd0) ? 1 : int'(cfg);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        for (int k = 0; k < spp; k++)
          pix_q.push_back('{x: 10'(x), y: 10'(y), last: (k == spp - 1), due: 0});
    issued = 0;
    bus.spp_cfg = cfg;
    bus.start = 1'b1;
    s = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_issued(input int n);
    int b;
    b = 0;
    while (issued < n && b < 200) begin
      tick();
      b++;
    end
    if (issued < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_issued got %0d want %0d", issued, n);
    end
  endtask

  task automatic wait_done(input int d0);
    int b;
    b = 0;
    while (done_cnt == d0 && b < 300) begin
      tick();
      b++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_done_timeout got none want pulse");
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({bus.pixel_valid, bus.tag_valid, bus.tag_last, bus.busy, bus.frame_done} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %05b want 00000",
               {bus.pixel_valid, bus.tag_valid, bus.tag_last, bus.busy, bus.frame_done});
    end
    n_cmp++;
    if ({bus.pixel_x, bus.pixel_y, bus.tag_x, bus.tag_y, bus.frame_count} !== 56'd0) begin
      n_bad++;
      $display("FAIL reset_fields got %0h want 0",
               {bus.pixel_x, bus.pixel_y, bus.tag_x, bus.tag_y, bus.frame_count});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle got busy=%0b want 0", bus.busy);
    end
  endtask

  task automatic test_frame();
    int s, d0;
    d0 = done_cnt;
    start_frame(4'd2, s);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.pixel_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_start got busy=%0b valid=%0b want 1 1", bus.busy, bus.pixel_valid);
    end
    wait_done(d0);
    n_cmp++;
    if (done_cyc != s + 1 + 24 + LAT) begin
      n_bad++;
      $display("FAIL frame_done_time got %0d want %0d", done_cyc, s + 1 + 24 + LAT);
    end
    exp_count++;
    repeat (3) tick();
    n_cmp++;
    if (bus.frame_count !== 16'(exp_count) || done_cnt != d0 + 1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_end got count=%0d pulses=%0d busy=%0b want %0d 1 0",
               bus.frame_count, done_cnt - d0, bus.busy, exp_count);
    end
    n_cmp++;
    if (issued != 24 || pix_q.size() != 0 || tag_q.size() != 0) begin
      n_bad++;
      $display("FAIL frame_issues got %0d left=%0d/%0d want 24 0/0",
               issued, pix_q.size(), tag_q.size());
    end
  endtask

  task automatic test_stall();
    int s, d0;
    d0 = done_cnt;
    start_frame(4'd2, s);
    wait_issued(7);
    bus.stall = 1'b1;
    repeat (5) tick();
    bus.stall = 1'b0;
    n_cmp++;
    if (issued != 7 || bus.pixel_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_freeze got issued=%0d valid=%0b want 7 1", issued, bus.pixel_valid);
    end
    wait_done(d0);
    n_cmp++;
    if (done_cyc != s + 1 + 24 + LAT + 5) begin
      n_bad++;
      $display("FAIL stall_done_time got %0d want %0d", done_cyc, s + 1 + 24 + LAT + 5);
    end
    exp_count++;
    tick();
    n_cmp++;
    if (bus.frame_count !== 16'(exp_count)) begin
      n_bad++;
      $display("FAIL stall_count got %0d want %0d", bus.frame_count, exp_count);
    end
  endtask

  task automatic test_abort();
    int s, d0;
    d0 = done_cnt;
    start_frame(4'd2, s);
    wait_issued(10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_cmp++;
    if ({bus.pixel_valid, bus.tag_valid, bus.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_idle got valid/tag/busy=%03b want 000",
               {bus.pixel_valid, bus.tag_valid, bus.busy});
    end
    repeat (10) tick();
    n_cmp++;
    if (done_cnt != d0 || bus.frame_count !== 16'(exp_count)) begin
      n_bad++;
      $display("FAIL abort_no_done got pulses=%0d count=%0d want 0 %0d",
               done_cnt - d0, bus.frame_count, exp_count);
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.pixel_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_beats_start got busy=%0b want 0", bus.busy);
    end
    start_frame(4'd3, s);
    wait_done(d0);
    n_cmp++;
    if (done_cyc != s + 1 + 36 + LAT || issued != 36) begin
      n_bad++;
      $display("FAIL restart got t=%0d issued=%0d want %0d 36", done_cyc, issued, s + 1 + 36 + LAT);
    end
    exp_count++;
    tick();
    n_cmp++;
    if (bus.frame_count !== 16'(exp_count)) begin
      n_bad++;
      $display("FAIL restart_count got %0d want %0d", bus.frame_count, exp_count);
    end
  endtask

  task automatic test_spp0_busy_start();
    int s, d0;
    d0 = done_cnt;
    start_frame(4'd0, s);
    repeat (3) tick();
    bus.spp_cfg = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(d0);
    n_cmp++;
    if (done_cyc != s + 1 + 12 + LAT || issued != 12) begin
      n_bad++;
      $display("FAIL spp0 got t=%0d issued=%0d want %0d 12", done_cyc, issued, s + 1 + 12 + LAT);
    end
    exp_count++;
    tick();
    n_cmp++;
    if (bus.frame_count !== 16'(exp_count) || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL spp0_count got %0d busy=%0b want %0d 0", bus.frame_count, bus.busy, exp_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int s;
    start_frame(4'd2, s);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.pixel_valid, bus.tag_valid, bus.busy, bus.frame_done, bus.pixel_x, bus.pixel_y,
         bus.tag_x, bus.tag_y, bus.frame_count} !== 60'd0) begin
      n_bad++;
      $display("FAIL reset_async got valid=%0b busy=%0b x=%0d count=%0d want all 0",
               bus.pixel_valid, bus.busy, bus.pixel_x, bus.frame_count);
    end
    pix_q.delete();
    tag_q.delete();
    exp_count = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.pixel_valid !== 1'b0 || bus.frame_count !== 16'(exp_count)) begin
      n_bad++;
      $display("FAIL reset_release got busy=%0b valid=%0b want 0 0", bus.busy, bus.pixel_valid);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    bus.spp_cfg = 4'd0;
    test_reset();
    test_frame();
    test_stall();
    test_abort();
    test_spp0_busy_start();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
